// File: rtl/transceiver_pkg.sv
// rtl/transceiver_pkg.sv - shared scheduler state encoding, widths and helpers
package transceiver_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int CNT_WIDTH          = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GUARD     = 3'd4
  } sched_state_e;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mod_scheduler_if.sv
// rtl/mod_scheduler_if.sv - receiver-side and modulator-side handshake bundle
interface mod_scheduler_if
  import transceiver_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] enc_data;
  logic                  mod_start;
  logic                  mod_done;

  modport master (output rx_data, rx_valid, mod_done, input enc_data, mod_start);
  modport slave  (input rx_data, rx_valid, mod_done, output enc_data, mod_start);
endinterface

// File: rtl/sched_fifo.sv
// rtl/sched_fifo.sv - pointer-plus-count synchronous FIFO for received bytes
module sched_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/mod_scheduler.sv
// rtl/mod_scheduler.sv - paces buffered UART bytes into modulator frames with timeout and guard gap
module mod_scheduler
  import transceiver_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH     = 4,
  parameter int GUARD_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 en,
  mod_scheduler_if.slave       bus,
  output logic                 busy,
  output logic                 fifo_full,
  output logic                 overflow,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [CNT_WIDTH-1:0] frame_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  sched_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] enc_data_q, enc_data_d;
  logic                  mod_start_q, mod_start_d;
  logic                  busy_q, busy_d;
  logic                  overflow_q, overflow_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic [GW-1:0]         guard_cnt_q, guard_cnt_d;

  logic                  pop, push, drop;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;

  // A pop frees a slot on the same edge, so a full FIFO still accepts then.
  assign pop  = (state_q == ST_IDLE) && en && !fifo_empty;
  assign push = bus.rx_valid && (!fifo_full || pop);
  assign drop = bus.rx_valid && fifo_full && !pop;

  sched_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .arstn (arstn),
    .push  (push),
    .wdata (bus.rx_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    enc_data_d    = enc_data_q;
    overflow_d    = overflow_q;
    timeout_err_d = timeout_err_q;
    drop_cnt_d    = drop_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    guard_cnt_d   = guard_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d    = ST_LOAD;
          enc_data_d = fifo_rdata;
        end
      end
      ST_LOAD:  state_d = ST_START;
      ST_START: begin
        state_d   = ST_WAIT_DONE;
        tmo_cnt_d = '0;
      end
      ST_WAIT_DONE: begin
        // A done strobe on the timeout edge still counts as a completed frame.
        if (bus.mod_done) begin
          state_d     = ST_GUARD;
          frame_cnt_d = frame_cnt_q + 1'b1;
          guard_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d       = ST_GUARD;
          timeout_err_d = 1'b1;
          guard_cnt_d   = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_GUARD: begin
        if (guard_cnt_q == GUARD_LAST) state_d = ST_IDLE;
        else                           guard_cnt_d = guard_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
    mod_start_d = (state_d == ST_START);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q       <= ST_IDLE;
      enc_data_q    <= '0;
      mod_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      drop_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      tmo_cnt_q     <= '0;
      guard_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      enc_data_q    <= enc_data_d;
      mod_start_q   <= mod_start_d;
      busy_q        <= busy_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
      drop_cnt_q    <= drop_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      guard_cnt_q   <= guard_cnt_d;
    end
  end

  assign bus.enc_data  = enc_data_q;
  assign bus.mod_start = mod_start_q;
  assign busy          = busy_q;
  assign overflow      = overflow_q;
  assign timeout_err   = timeout_err_q;
  assign drop_cnt      = drop_cnt_q;
  assign frame_cnt     = frame_cnt_q;
endmodule

// File: tb/tb_mod_scheduler.sv
// tb/tb_mod_scheduler.sv - directed and randomized checks of mod_scheduler
module tb_mod_scheduler;
  import transceiver_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int GUARD = 16;
  localparam int TMO   = 64;
  localparam int HUGE  = 32'h3fff_ffff;

  logic       clk = 1'b0;
  logic       arstn, en;
  logic       busy, fifo_full, overflow, timeout_err;
  logic [7:0] drop_cnt, frame_cnt;
  int         n_checks = 0;
  int         n_fail = 0;
  int         starts;

  logic [7:0] burst [6];
  logic [7:0] mq [$];
  logic [7:0] cur_m, rd;
  int         free_edge, start_edge, wait_entry, dly, drop_m, frame_m;
  bit         waiting, ovf_m, tmo_m, popped, full_before, rv, dn, en_r;

  mod_scheduler_if #(.DATA_WIDTH(DW)) bus ();

  mod_scheduler #(
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (DEPTH),
    .GUARD_CYCLES   (GUARD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .arstn       (arstn),
    .en          (en),
    .bus         (bus),
    .busy        (busy),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .drop_cnt    (drop_cnt),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      tick();
      if (bus.mod_start === 1'b1) starts++;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_enc"}, bus.enc_data, 0);
    check({tag, "_start"}, bus.mod_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_full"}, fifo_full, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_tmo"}, timeout_err, 0);
    check({tag, "_drop"}, drop_cnt, 0);
    check({tag, "_frame"}, frame_cnt, 0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (bus.mod_start !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, 32'(n < 300), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(n < 300), 1);
  endtask

  task automatic serve(input logic [7:0] exp, input int d, input string tag);
    wait_start(tag);
    check({tag, "_data"}, bus.enc_data, exp);
    repeat (d - 1) tick();
    bus.mod_done = 1'b1;
    tick();
    bus.mod_done = 1'b0;
  endtask

  initial begin
    arstn = 1'b0; en = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.mod_done = 1'b0;
    repeat (3) tick();
    check_reset("reset");
    arstn = 1'b1;
    tick();

    // single byte, done 20 cycles after mod_start
    en = 1'b1;
    push_byte(8'hA5);
    check("t1_busy_k", busy, 0);
    tick();
    check("t1_enc_k1", bus.enc_data, 8'hA5);
    check("t1_busy_k1", busy, 1);
    check("t1_nostart_k1", bus.mod_start, 0);
    tick();
    check("t1_start_k2", bus.mod_start, 1);
    tick();
    check("t1_start_fall_k3", bus.mod_start, 0);
    starts = 0;
    run(18);
    bus.mod_done = 1'b1;
    tick();
    bus.mod_done = 1'b0;
    check("t1_one_pulse", starts, 0);
    check("t1_frame", frame_cnt, 1);
    run(GUARD - 1);
    check("t1_busy_guard", busy, 1);
    tick();
    check("t1_busy_low", busy, 0);
    check("t1_tmo", timeout_err, 0);

    // burst of six bytes into a depth-4 FIFO
    burst[0] = 8'h10; burst[1] = 8'h21; burst[2] = 8'h32;
    burst[3] = 8'h43; burst[4] = 8'h54; burst[5] = 8'h65;
    for (int i = 0; i < 6; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = burst[i];
      tick();
      if (i == 2) begin
        check("t2_start0", bus.mod_start, 1);
        check("t2_data0", bus.enc_data, burst[0]);
      end
    end
    bus.rx_valid = 1'b0;
    tick();
    check("t2_ovf", overflow, 1);
    check("t2_drop", drop_cnt, 1);
    check("t2_full", fifo_full, 1);
    bus.mod_done = 1'b1;
    tick();
    bus.mod_done = 1'b0;
    serve(burst[1], 3, "t2_b1");
    serve(burst[2], 5, "t2_b2");
    serve(burst[3], 2, "t2_b3");
    serve(burst[4], 7, "t2_b4");
    check("t2_frame", frame_cnt, 6);
    check("t2_drop_end", drop_cnt, 1);

    // done on the very edge the timeout would fire
    push_byte(8'h3C);
    serve(8'h3C, TMO + 1, "t3a");
    check("t3a_tmo", timeout_err, 0);
    check("t3a_frame", frame_cnt, 7);

    // done withheld
    push_byte(8'hC1);
    push_byte(8'hC2);
    wait_start("t3b");
    check("t3b_data", bus.enc_data, 8'hC1);
    repeat (TMO) tick();
    check("t3b_tmo_before", timeout_err, 0);
    tick();
    check("t3b_tmo_set", timeout_err, 1);
    check("t3b_frame", frame_cnt, 7);
    repeat (GUARD + 1) tick();
    check("t3b_gap", bus.mod_start, 0);
    tick();
    check("t3b_next_start", bus.mod_start, 1);
    check("t3b_next_data", bus.enc_data, 8'hC2);
    tick();
    bus.mod_done = 1'b1;
    tick();
    bus.mod_done = 1'b0;
    check("t3b_frame2", frame_cnt, 8);

    // enable held low while bytes queue
    wait_idle("t4");
    en = 1'b0;
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    starts = 0;
    run(30);
    check("t4_nostart", starts, 0);
    check("t4_full", fifo_full, 0);
    check("t4_busy", busy, 0);
    en = 1'b1;
    serve(8'h01, 3, "t4_b1");
    serve(8'h02, 4, "t4_b2");
    serve(8'h03, 2, "t4_b3");
    check("t4_frame", frame_cnt, 11);

    // asynchronous reset during WAIT_DONE with bytes queued
    wait_idle("t5");
    push_byte(8'hE0);
    push_byte(8'hE1);
    push_byte(8'hE2);
    wait_start("t5");
    tick();
    tick();
    #2 arstn = 1'b0;
    #1 check_reset("t5_async");
    tick();
    arstn = 1'b1;
    starts = 0;
    run(40);
    check("t5_nostart", starts, 0);
    check("t5_busy", busy, 0);

    // push and pop on the same edge while full
    en = 1'b0;
    push_byte(8'hF0);
    push_byte(8'hF1);
    push_byte(8'hF2);
    push_byte(8'hF3);
    check("t6_full_before", fifo_full, 1);
    en = 1'b1;
    push_byte(8'hF4);
    check("t6_full_after", fifo_full, 1);
    check("t6_ovf", overflow, 0);
    check("t6_drop", drop_cnt, 0);
    serve(8'hF0, 2, "t6_b0");
    serve(8'hF1, 2, "t6_b1");
    serve(8'hF2, 2, "t6_b2");
    serve(8'hF3, 2, "t6_b3");
    serve(8'hF4, 2, "t6_b4");
    check("t6_frame", frame_cnt, 5);
    check("t6_ovf_end", overflow, 0);

    // randomized traffic against a frame-timing model
    arstn = 1'b0;
    tick();
    arstn = 1'b1;
    free_edge = 0; start_edge = -1; wait_entry = -100; dly = 0;
    waiting = 0; cur_m = '0; drop_m = 0; frame_m = 0; ovf_m = 0; tmo_m = 0;
    for (int e = 0; e < 3000; e++) begin
      rv   = ($urandom_range(0, 2) == 0);
      rd   = 8'($urandom);
      en_r = ($urandom_range(0, 7) != 0);
      dn   = (waiting && e == wait_entry + dly) || ($urandom_range(0, 29) == 0);
      en = en_r; bus.rx_valid = rv; bus.rx_data = rd; bus.mod_done = dn;
      @(posedge clk);
      full_before = (mq.size() == DEPTH);
      popped = en_r && (e >= free_edge) && (mq.size() != 0);
      if (waiting && e > wait_entry) begin
        if (dn) begin
          waiting = 0; frame_m = (frame_m + 1) % 256; free_edge = e + GUARD + 1;
        end else if (e == wait_entry + TMO) begin
          waiting = 0; tmo_m = 1; free_edge = e + GUARD + 1;
        end
      end
      if (popped) begin
        cur_m = mq.pop_front();
        start_edge = e + 1; wait_entry = e + 2;
        dly = $urandom_range(1, TMO + 2);
        waiting = 1; free_edge = HUGE;
      end
      if (rv) begin
        if (!full_before || popped) mq.push_back(rd);
        else begin
          ovf_m = 1;
          if (drop_m < 255) drop_m++;
        end
      end
      @(negedge clk);
      check("rnd_enc", bus.enc_data, cur_m);
      check("rnd_start", bus.mod_start, 32'(e == start_edge));
      check("rnd_busy", busy, 32'(popped || (e < free_edge - 1)));
      check("rnd_full", fifo_full, 32'(mq.size() == DEPTH));
      check("rnd_ovf", overflow, ovf_m);
      check("rnd_tmo", timeout_err, tmo_m);
      check("rnd_drop", drop_cnt, drop_m);
      check("rnd_frame", frame_cnt, frame_m);
    end
    bus.rx_valid = 1'b0;
    bus.mod_done = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mod_scheduler.md
# mod_scheduler

Frame scheduler between the UART receiver and the encoder/modulator chain of the transceiver. It buffers received bytes in a small FIFO and presents them one at a time to the encoder. For each byte it issues a start pulse to the modulator, waits for completion (with a timeout), then inserts a guard gap before the next frame. It also reports overflow, dropped-byte and sent-frame counts.

## Interface
Parameters:
- DATA_WIDTH, 8: byte width from the UART receiver.
- FIFO_DEPTH, 4: buffered bytes; power of two, minimum 2.
- GUARD_CYCLES, 16: idle clocks between the end of one frame and the start of the next; minimum 1.
- TIMEOUT_CYCLES, 4096: maximum clocks from mod_start to mod_done before the frame is abandoned.

Ports:
- clk  in  1  system clock, rising edge.
- arstn  in  1  asynchronous active-low reset.
- en  in  1  scheduling enable; the FIFO fills regardless of en.
- rx_data  in  DATA_WIDTH  byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe qualifying rx_data.
- enc_data  out  DATA_WIDTH  byte held stable to the encoder for the whole frame.
- mod_start  out  1  one-cycle start pulse to the modulator.
- mod_done  in  1  one-cycle completion strobe from the modulator.
- busy  out  1  high in every state except IDLE.
- fifo_full  out  1  FIFO count equals FIFO_DEPTH.
- overflow  out  1  sticky flag, set when a byte is dropped.
- timeout_err  out  1  sticky flag, set when a frame is abandoned.
- drop_cnt  out  8  dropped bytes; saturates at 255.
- frame_cnt  out  8  frames completed with mod_done; wraps 255→0.

## Operation
- Push: rx_valid=1 and FIFO not full → write rx_data.
- Drop: rx_valid=1, FIFO full and no pop on the same edge → byte discarded, overflow set, drop_cnt incremented (saturating).
- Push and pop on the same edge while full → push accepted; count unchanged.
- State machine (registered state):
  - IDLE → LOAD when en=1 and FIFO not empty. This transition pops the FIFO head into enc_data.
  - LOAD → START unconditionally.
  - START → WAIT_DONE unconditionally. mod_start=1 only while in START.
  - WAIT_DONE → GUARD on mod_done=1; frame_cnt increments.
  - WAIT_DONE → GUARD when the timeout counter reaches TIMEOUT_CYCLES; timeout_err is set.
  - GUARD → IDLE after GUARD_CYCLES clocks in GUARD.
- mod_done=1 on the same edge as the timeout → treated as done; no error.
- mod_done outside WAIT_DONE is ignored.
- en falls mid-frame → the current frame completes normally; the block then holds in IDLE. Bytes stay queued.
- Flags are cleared only by reset.

## Timing
- Reset values: enc_data=0, mod_start=0, busy=0, fifo_full=0, overflow=0, timeout_err=0, drop_cnt=0, frame_cnt=0. FIFO empty, state IDLE.
- Reset asserted mid-frame → all of the above apply immediately (asynchronous), including mod_start=0. Queued bytes are lost.
- Latency: rx_valid sampled at edge k into an empty FIFO with en=1, state IDLE:
  - edge k+1: pop, enc_data valid.
  - edge k+2: mod_start rises.
  - edge k+3: mod_start falls.
- enc_data is stable from edge k+1 until the next pop.
- Timeout counter starts at 0 on entry to WAIT_DONE and increments each cycle.
- Minimum spacing between mod_start pulses: 3 + GUARD_CYCLES + (cycles spent in WAIT_DONE).
- busy is registered alongside state; it rises one edge after the pop decision.
- fifo_full and the counters are registered; they update on the edge after the causing event.

## Structure
- Shared package transceiver_pkg holds:
  - FSM state encoding (IDLE, LOAD, START, WAIT_DONE, GUARD, 3 bits);
  - default DATA_WIDTH;
  - counter width of 8 for drop_cnt and frame_cnt.
- Sub-module sched_fifo: synchronous FIFO with pointer-plus-count, push/pop/full/empty, parameterised on DATA_WIDTH and FIFO_DEPTH. The FSM, guard/timeout counters and flags remain in mod_scheduler.

## Test plan
- Single byte 0xA5, mod_done 20 cycles after mod_start:
  - enc_data=0xA5 at edge k+1;
  - one mod_start pulse at edge k+2;
  - frame_cnt=1;
  - busy low GUARD_CYCLES cycles after mod_done.
- Burst of 6 bytes back-to-back, mod_done never returned within the burst:
  - first byte popped immediately; with FIFO_DEPTH=4 the last byte is dropped;
  - overflow=1, drop_cnt=1;
  - remaining 4 bytes sent in order after done strobes.
- mod_done withheld:
  - timeout_err=1 exactly TIMEOUT_CYCLES cycles after WAIT_DONE entry;
  - frame_cnt unchanged;
  - next queued byte starts after the guard gap.
- en=0 with 3 bytes pushed: no mod_start, fifo_full=0. Raising en drains the 3 bytes in order (0x01, 0x02, 0x03).
- arstn pulsed low during WAIT_DONE with 2 bytes queued: all outputs reach reset values; no mod_start after release until a new rx_valid.
- Push on the same edge as a pop with the FIFO full: byte accepted, overflow stays 0.
